// File: rtl/fifo_wr_cntrl.sv
// rtl/fifo_wr_cntrl.sv - write-domain pointer, full/almost-full and overflow control for an async FIFO
module fifo_wr_cntrl #(
    parameter int unsigned MEM_DEPTH = 8,
    parameter int unsigned AFULL_TH  = 6
) (
    input  logic                         W_CLK,
    input  logic                         W_RST,
    input  logic                         W_INC,
    input  logic                         W_OVF_CLR,
    input  logic [$clog2(MEM_DEPTH):0]   wq2_rptr,
    output logic                         W_EN,
    output logic [$clog2(MEM_DEPTH)-1:0] W_addr,
    output logic [$clog2(MEM_DEPTH):0]   wptr,
    output logic                         W_FULL,
    output logic                         W_AFULL,
    output logic [$clog2(MEM_DEPTH):0]   W_LEVEL,
    output logic                         W_OVF
);

    localparam int unsigned A = $clog2(MEM_DEPTH);
    localparam int unsigned P = A + 1;
    localparam logic [P-1:0] AFULL_LVL = P'(AFULL_TH);

    logic [P-1:0] wbin;
    logic [P-1:0] wbin_next;
    logic [P-1:0] wgray_next;
    logic [P-1:0] full_ptr;
    logic [P-1:0] rbin;
    logic         full_next;

    assign W_EN       = W_INC & ~W_FULL;
    assign W_addr     = wbin[A-1:0];
    assign wbin_next  = wbin + {{(P-1){1'b0}}, W_EN};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Full when the write pointer has lapped the read pointer once: top two Gray bits inverted.
    assign full_ptr  = {~wq2_rptr[P-1:P-2], wq2_rptr[P-3:0]};
    assign full_next = (wgray_next == full_ptr);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < int'(P); i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign W_LEVEL = wbin - rbin;
    assign W_AFULL = (W_LEVEL >= AFULL_LVL);

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wbin   <= '0;
            wptr   <= '0;
            W_FULL <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            W_FULL <= full_next;
        end
    end

    // A rejected write in the same cycle as a clear keeps the error visible.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            W_OVF <= 1'b0;
        end else if (W_INC && W_FULL) begin
            W_OVF <= 1'b1;
        end else if (W_OVF_CLR) begin
            W_OVF <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_cntrl.sv
// tb/tb_fifo_wr_cntrl.sv - directed self-checking bench for fifo_wr_cntrl (MEM_DEPTH=8, AFULL_TH=6)
module tb_fifo_wr_cntrl;

    logic       clk;
    logic       rst_n;
    logic       w_inc;
    logic       w_ovf_clr;
    logic [3:0] rq;
    logic       w_en;
    logic [2:0] w_addr;
    logic [3:0] wptr;
    logic       w_full;
    logic       w_afull;
    logic [3:0] w_level;
    logic       w_ovf;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_cntrl #(.MEM_DEPTH(8), .AFULL_TH(6)) dut (
        .W_CLK     (clk),
        .W_RST     (rst_n),
        .W_INC     (w_inc),
        .W_OVF_CLR (w_ovf_clr),
        .wq2_rptr  (rq),
        .W_EN      (w_en),
        .W_addr    (w_addr),
        .wptr      (wptr),
        .W_FULL    (w_full),
        .W_AFULL   (w_afull),
        .W_LEVEL   (w_level),
        .W_OVF     (w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev;
    int k;

    initial begin
        rst_n = 1'b0; w_inc = 1'b0; w_ovf_clr = 1'b0; rq = 4'b0000;
        #12;
        check("rst_wptr",  32'(wptr),    32'h0);
        check("rst_full",  32'(w_full),  32'h0);
        check("rst_ovf",   32'(w_ovf),   32'h0);
        check("rst_level", 32'(w_level), 32'h0);
        check("rst_addr",  32'(w_addr),  32'h0);
        check("rst_afull", 32'(w_afull), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_wptr", 32'(wptr), 32'h0);
        check("idle_en",   32'(w_en), 32'h0);

        // Fill all eight entries with the reader parked at zero
        w_inc = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("fill_addr",  32'(w_addr),  32'(i));
            check("fill_en",    32'(w_en),    32'h1);
            check("fill_level", 32'(w_level), 32'(i));
            check("fill_afull", 32'(w_afull), (i >= 6) ? 32'h1 : 32'h0);
            check("fill_full",  32'(w_full),  32'h0);
            step();
        end
        check("full_wptr",  32'(wptr),    32'hC);
        check("full_level", 32'(w_level), 32'h8);
        check("full_flag",  32'(w_full),  32'h1);
        check("full_afull", 32'(w_afull), 32'h1);

        // Overflow: rejected write, sticky flag, set beats clear, then clear
        check("ovf_en", 32'(w_en), 32'h0);
        step();
        check("ovf_wptr", 32'(wptr),  32'hC);
        check("ovf_set",  32'(w_ovf), 32'h1);
        w_inc = 1'b0;
        step();
        check("ovf_hold", 32'(w_ovf), 32'h1);
        w_inc = 1'b1; w_ovf_clr = 1'b1;
        step();
        check("ovf_set_wins", 32'(w_ovf), 32'h1);
        check("ovf_wptr2",    32'(wptr),  32'hC);
        w_inc = 1'b0;
        step();
        check("ovf_clr", 32'(w_ovf), 32'h0);
        w_ovf_clr = 1'b0;

        // Reader advances one entry
        rq = 4'b0001;
        #1;
        check("rd1_level_comb", 32'(w_level), 32'h7);
        step();
        check("rd1_full",  32'(w_full),  32'h0);
        check("rd1_level", 32'(w_level), 32'h7);
        check("rd1_afull", 32'(w_afull), 32'h1);

        // Clean restart, then 20 writes with the reader two entries behind
        @(negedge clk);
        rst_n = 1'b0; rq = 4'b0000;
        #1;
        check("rst2_wptr", 32'(wptr),   32'h0);
        check("rst2_full", 32'(w_full), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        k = 0;
        w_inc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rq = (k >= 2) ? gray(4'(k - 2)) : 4'b0000;
            #1;
            check("wrap_addr", 32'(w_addr), 32'(k % 8));
            check("wrap_en",   32'(w_en),   32'h1);
            prev = wptr;
            step();
            k++;
            check("wrap_wptr", 32'(wptr),   32'(gray(4'(k))));
            check("wrap_step", 32'($countones(wptr ^ prev)), 32'h1);
            check("wrap_full", 32'(w_full), 32'h0);
        end
        check("wrap_final", 32'(wptr), 32'h6);

        // Reset asserted mid-burst after five writes
        @(negedge clk);
        rst_n = 1'b0; rq = 4'b0000; w_inc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; w_inc = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("burst_wptr", 32'(wptr), 32'(gray(4'd5)));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wptr", 32'(wptr),   32'h0);
        check("async_full", 32'(w_full), 32'h0);
        check("async_addr", 32'(w_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_addr", 32'(w_addr), 32'h0);
        check("post_en",   32'(w_en),   32'h1);
        step();
        check("post_wptr",  32'(wptr),   32'h1);
        check("post_addr1", 32'(w_addr), 32'h1);
        w_inc = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_cntrl.md
FIFO_WR_CNTRL -- requirements
Module: fifo_wr_cntrl

Interface
REQ-001 Parameter MEM_DEPTH, default 8, FIFO entries; SHALL be a power of two, at least 4.
REQ-002 Parameter AFULL_TH, default 6, fill level at or above which almost-full SHALL assert; range 1..MEM_DEPTH.
REQ-003 Local A = $clog2(MEM_DEPTH); pointer width P = A+1.
REQ-004 W_CLK  in  1  write-domain clock; all state SHALL update on its rising edge.
REQ-005 W_RST  in  1  reset; asynchronous assertion, active-low.
REQ-006 W_INC  in  1  write request from producer, one entry per cycle.
REQ-007 W_OVF_CLR  in  1  synchronous clear of overflow flag.
REQ-008 wq2_rptr  in  P  read pointer, Gray-coded, already synchronized into W_CLK domain.
REQ-009 W_EN  out  1  write strobe to FIFO memory.
REQ-010 W_addr  out  A  memory write address.
REQ-011 wptr  out  P  registered Gray write pointer, sent to read-domain synchronizer.
REQ-012 W_FULL  out  1  registered full flag.
REQ-013 W_AFULL  out  1  almost-full flag.
REQ-014 W_LEVEL  out  P  current fill level, 0..MEM_DEPTH.
REQ-015 W_OVF  out  1  sticky overflow error.

Function
REQ-016 Internal binary write pointer wbin (P bits); wptr SHALL equal registered Gray(wbin): wbin ^ (wbin >> 1).
REQ-017 W_EN SHALL be combinational W_INC & ~W_FULL; W_addr SHALL be wbin[A-1:0].
REQ-018 On each edge with W_EN=1, wbin SHALL increment by 1 modulo 2^P; otherwise it SHALL hold.
REQ-019 wbin_next = wbin + W_EN; wptr SHALL register Gray(wbin_next) on the same edge.
REQ-020 W_FULL SHALL register (Gray(wbin_next) == {~wq2_rptr[P-1:P-2], wq2_rptr[P-3:0]}) every cycle.
REQ-021 W_FULL SHALL deassert on the edge after wq2_rptr advances, provided no write occurs.
REQ-022 Binary read pointer rbin SHALL be Gray-to-binary of wq2_rptr (combinational, XOR prefix from MSB).
REQ-023 W_LEVEL SHALL be (wbin - rbin) modulo 2^P, combinational from registered wbin and wq2_rptr.
REQ-024 W_AFULL SHALL be combinational (W_LEVEL >= AFULL_TH).
REQ-025 W_INC=1 while W_FULL=1 SHALL leave wbin unchanged and set W_OVF on that edge.
REQ-026 W_OVF SHALL hold until W_OVF_CLR=1 clears it; a simultaneous set and clear SHALL leave W_OVF=1.
REQ-027 Pointer wrap (wbin 2^P-1 -> 0) SHALL need no special handling; Gray wptr changes exactly one bit per increment.
REQ-028 wptr SHALL change at most one bit per W_CLK edge.

Reset
REQ-029 W_RST=0 SHALL immediately force wbin=0, wptr=0, W_FULL=0, W_OVF=0, regardless of W_CLK.
REQ-030 After reset with wq2_rptr=0, outputs SHALL read W_addr=0, W_LEVEL=0, W_AFULL=0, W_EN=W_INC.
REQ-031 Reset asserted mid-burst SHALL discard pointer state; the first write after release SHALL target address 0.

Verification (MEM_DEPTH=8, AFULL_TH=6)
REQ-032 Reset, W_INC=0 -> wptr=0000, W_FULL=0, W_OVF=0, W_LEVEL=0, W_addr=0.
REQ-033 wq2_rptr=0, W_INC=1 for 8 cycles -> W_addr 0..7 with W_EN=1 each; W_AFULL=1 once W_LEVEL=6; after 8th edge wptr=1100, W_LEVEL=8, W_FULL=1.
REQ-034 Full, W_INC=1 one cycle -> W_EN=0, wptr stays 1100, W_OVF=1; W_OVF_CLR=1 -> W_OVF=0 next edge.
REQ-035 Full, wq2_rptr set to 0001, W_INC=0 -> W_FULL=0 after one edge, W_LEVEL=7.
REQ-036 Continuous writes with wq2_rptr tracking 2 entries behind, 20 writes -> wbin wraps 15->0, wptr 1000->0000, W_FULL never asserts, every wptr step changes exactly one bit.
REQ-037 W_RST pulsed low mid-write after 5 writes -> wptr=0000 and W_FULL=0 asynchronously; next write uses W_addr=0.
